// File: rtl/uart_receiver_if.sv
// -----------------------------------------------------------------------------
// uart_receiver_if
//   Host-side bundle of the UART receiver: received byte, status flags and the
//   flag-clear strobe.
//
//   Signals:
//     rdy_clr    host -> receiver  one-cycle pulse, clears rdy/frame_err/overrun
//     dout[7:0]  receiver -> host  last correctly received byte
//     rdy        receiver -> host  sticky: new byte available in dout
//     frame_err  receiver -> host  sticky: stop bit sampled as 0
//     overrun    receiver -> host  sticky: byte completed while rdy was still 1
//     busy       receiver -> host  receiver FSM is not idle
//
//   Modports:
//     master  the host (drives rdy_clr)
//     slave   the receiver (drives data and status)
// -----------------------------------------------------------------------------
interface uart_receiver_if;
    logic       rdy_clr;
    logic [7:0] dout;
    logic       rdy;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        output rdy_clr,
        input  dout,
        input  rdy,
        input  frame_err,
        input  overrun,
        input  busy
    );

    modport slave (
        input  rdy_clr,
        output dout,
        output rdy,
        output frame_err,
        output overrun,
        output busy
    );
endinterface

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//   Receive half of an 8N1 UART. The rx pin is synchronised, sampled with a
//   free-running 16x oversample tick and each bit is decided by a majority
//   vote of samples 7, 8 and 9 of its 16-tick window. Received bytes are
//   presented with a sticky rdy flag; framing and overrun errors are reported
//   with sticky flags. All flags are cleared by a rdy_clr pulse.
//
//   Parameters:
//     TICK_DIV  clk_50m cycles per oversample tick (>= 2)
//
//   Ports:
//     clk_50m  system clock, all registers update on its rising edge
//     reset    synchronous, active-high reset
//     rx       asynchronous serial input, idles high
//     host     host-side bundle (slave modport of uart_receiver_if)
// -----------------------------------------------------------------------------
module uart_receiver #(
    parameter int TICK_DIV = 27
) (
    input  logic              clk_50m,
    input  logic              reset,
    input  logic              rx,
    uart_receiver_if.slave    host
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t          state_reg;
    logic [1:0]      sync_reg;
    logic [TW-1:0]   tick_cnt_reg;
    logic [3:0]      s_cnt_reg;
    logic [1:0]      samp_reg;
    logic [2:0]      bit_idx_reg;
    logic [7:0]      shift_reg;
    logic [7:0]      dout_reg;
    logic            rdy_reg;
    logic            frame_err_reg;
    logic            overrun_reg;
    logic            busy_reg;

    logic            rxs;
    logic            tick;
    logic            maj;

    assign rxs  = sync_reg[1];
    assign tick = (tick_cnt_reg == TICK_LAST);
    // Samples 7 and 8 are held in samp_reg; sample 9 is the live rxs value,
    // so the vote is only meaningful on the tick where s_cnt equals 9.
    assign maj  = (samp_reg[0] & samp_reg[1]) |
                  (samp_reg[0] & rxs) |
                  (samp_reg[1] & rxs);

    always_ff @(posedge clk_50m) begin
        if (reset) begin
            sync_reg      <= 2'b11;
            tick_cnt_reg  <= '0;
            state_reg     <= IDLE;
            s_cnt_reg     <= 4'd0;
            samp_reg      <= 2'b00;
            bit_idx_reg   <= 3'd0;
            shift_reg     <= 8'h00;
            dout_reg      <= 8'h00;
            rdy_reg       <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            sync_reg     <= {sync_reg[0], rx};
            // Never re-aligned to frames: start detection jitters by up to
            // one tick, which the mid-window vote absorbs.
            tick_cnt_reg <= tick ? '0 : tick_cnt_reg + TW'(1);

            // Clears come first so that a coincident commit or framing
            // error, assigned further down, takes precedence.
            if (host.rdy_clr) begin
                rdy_reg       <= 1'b0;
                frame_err_reg <= 1'b0;
                overrun_reg   <= 1'b0;
            end

            if (tick) begin
                if (state_reg != IDLE) begin
                    s_cnt_reg <= s_cnt_reg + 4'd1;
                    if (s_cnt_reg == 4'd7) samp_reg[0] <= rxs;
                    if (s_cnt_reg == 4'd8) samp_reg[1] <= rxs;
                end

                case (state_reg)
                    IDLE: begin
                        if (!rxs) begin
                            s_cnt_reg <= 4'd0;
                            state_reg <= START;
                            busy_reg  <= 1'b1;
                        end
                    end
                    START: begin
                        if (s_cnt_reg == 4'd9 && maj) begin
                            // Start bit did not survive to mid-window: glitch.
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end else if (s_cnt_reg == 4'd15) begin
                            state_reg   <= DATA;
                            bit_idx_reg <= 3'd0;
                        end
                    end
                    DATA: begin
                        if (s_cnt_reg == 4'd9) begin
                            shift_reg <= {maj, shift_reg[7:1]};
                        end
                        if (s_cnt_reg == 4'd15) begin
                            if (bit_idx_reg == 3'd7) begin
                                state_reg <= STOP;
                            end else begin
                                bit_idx_reg <= bit_idx_reg + 3'd1;
                            end
                        end
                    end
                    STOP: begin
                        if (s_cnt_reg == 4'd9) begin
                            if (maj) begin
                                // Leave early so the next start edge, due
                                // about 6 ticks later, is not missed.
                                state_reg <= IDLE;
                                busy_reg  <= 1'b0;
                                if (!rdy_reg || host.rdy_clr) begin
                                    dout_reg <= shift_reg;
                                    rdy_reg  <= 1'b1;
                                end else begin
                                    overrun_reg <= 1'b1;
                                end
                            end else begin
                                frame_err_reg <= 1'b1;
                                state_reg     <= WAIT_HIGH;
                            end
                        end
                    end
                    WAIT_HIGH: begin
                        // A held-low line (break) must not look like a
                        // stream of start bits.
                        if (rxs) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign host.dout      = dout_reg;
    assign host.rdy       = rdy_reg;
    assign host.frame_err = frame_err_reg;
    assign host.overrun   = overrun_reg;
    assign host.busy      = busy_reg;

endmodule
